lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencer between the core's memory stage and the data-memory port. Accepts one load or store per handshake, checks alignment, drives a word-aligned bus request with byte strobes, waits for read data, lane-shifts it, and runs it through an `extend` instance to produce the sign- or zero-extended result. Single outstanding transaction; the core stalls on `req_ready`.

## Interface
- No parameters; address and data widths are fixed at 32.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core presents a memory operation.
- `req_ready` out 1: high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_ctrl` in 3: EXT_* size/sign code.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal code; qualified by `resp_valid`.
- `mem_valid` out 1: bus request.
- `mem_ready` in 1: bus accepts the request.
- `mem_we` out 1: bus write enable.
- `mem_addr` out 32: `{req_addr[31:2], 2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte strobes; 0 for loads.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, register we, addr, wdata, ctrl.
  - Legal → ISSUE.
  - Illegal → RESP with err=1, no bus access.
- Illegal: HALF/HALFU with addr[0]=1; WORD with addr[1:0]≠0; any code outside the five EXT_* values.
- ISSUE: `mem_valid`=1, bus fields held stable until `mem_ready`.
  - Store + ready → RESP.
  - Load + ready + rvalid in the same cycle → RESP.
  - Load + ready without rvalid → WAIT.
- WAIT: hold until `mem_rvalid`, capture `mem_rdata >> (8*addr[1:0])`, → RESP.
- RESP: `resp_valid`=1 for exactly one cycle, → IDLE. No backpressure on the response.
- Store lanes:
  - BYTE/BYTEU: strb = `4'b0001 << addr[1:0]`, wdata = `{4{wdata[7:0]}}`.
  - HALF/HALFU: strb = `4'b0011 << addr[1:0]`, wdata = `{2{wdata[15:0]}}`.
  - WORD: strb = 4'b1111.
- Load result: the shifted word goes to `extend` with the registered ctrl; its output is registered into `resp_rdata`.
- `mem_rvalid` outside ISSUE/WAIT is ignored, including a stale response after reset.

## Timing
- Reset values: state IDLE, `req_ready`=1, every other output 0.
- Reset mid-transaction abandons the transaction: the state returns to IDLE and no `resp_valid` is produced.
- Accept at cycle 0. Earliest response:
  - Store, or load with same-cycle `mem_ready`+`mem_rvalid`: `resp_valid` at cycle 2.
  - Load with rvalid one cycle after ready: cycle 3.
  - Illegal request: cycle 1.
- Each bus wait cycle adds one cycle of latency.
- `req_ready` is low from cycle 1 until the cycle after RESP.
- Back-to-back throughput: one operation per 3 cycles minimum.

## Structure
- The EXT_BYTE/HALF/WORD/BYTEU/HALFU codes and the state enum live in the shared `signals.svh` include; no local redefinition.
- One sub-module: the existing `extend`, instantiated once on the load path.
- Alignment check and strobe/replicate logic are combinational inside `lsu_ctrl`.

## Test plan
- Load BYTE at 0x103, `mem_rdata`=0x80AB_CDEF, rvalid one cycle after ready → `mem_addr`=0x100, `resp_rdata`=0xFFFF_FF80 at cycle 3.
- Load HALFU at 0x102, rdata=0x8001_1234, ready+rvalid together → `resp_rdata`=0x0000_8001 at cycle 2.
- Store HALF at 0x206, wdata=0xDEAD_BEEF, `mem_ready` delayed 2 cycles → wstrb=4'b1100, wdata=0xBEEF_BEEF held stable, resp at cycle 4.
- Load WORD at 0x101 → no `mem_valid`, `resp_valid`+`resp_err` at cycle 1, rdata 0.
- Reset asserted in WAIT, then spurious `mem_rvalid` after release → all outputs 0, no response, next request accepted normally.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store sequencer: extend codes, FSM states
// and the alignment/legality helper.
package lsu_ctrl_pkg;

  localparam logic [2:0] EXT_BYTE  = 3'd0;
  localparam logic [2:0] EXT_HALF  = 3'd1;
  localparam logic [2:0] EXT_WORD  = 3'd2;
  localparam logic [2:0] EXT_BYTEU = 3'd4;
  localparam logic [2:0] EXT_HALFU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Unknown codes are illegal regardless of address.
  function automatic logic req_legal(input logic [2:0] ctrl, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (ctrl)
      EXT_BYTE, EXT_BYTEU: ok = 1'b1;
      EXT_HALF, EXT_HALFU: ok = ~addr_lo[0];
      EXT_WORD:            ok = (addr_lo == 2'b00);
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_ctrl_extend.sv
// Sign/zero extension of a right-aligned load word according to the EXT code.
module lsu_ctrl_extend
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] din,
  input  logic [2:0]  ctrl,
  output logic [31:0] dout
);

  always_comb begin
    dout = '0;
    case (ctrl)
      EXT_BYTE:  dout = {{24{din[7]}}, din[7:0]};
      EXT_HALF:  dout = {{16{din[15]}}, din[15:0]};
      EXT_WORD:  dout = din;
      EXT_BYTEU: dout = {24'd0, din[7:0]};
      EXT_HALFU: dout = {16'd0, din[15:0]};
      default:   dout = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store sequencer between the memory stage and the
// data-memory port: alignment check, strobes/lane replication, load extend.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ctrl,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] rd_shifted;
  logic [31:0] rd_ext;
  logic [31:0] st_wdata;
  logic [3:0]  st_strb;

  assign rd_shifted = mem_rdata >> {addr_q[1:0], 3'b000};

  lsu_ctrl_extend u_extend (
    .din  (rd_shifted),
    .ctrl (ctrl_q),
    .dout (rd_ext)
  );

  always_comb begin
    st_wdata = wdata_q;
    st_strb  = 4'b1111;
    case (ctrl_q)
      EXT_BYTE, EXT_BYTEU: begin
        st_wdata = {4{wdata_q[7:0]}};
        st_strb  = 4'b0001 << addr_q[1:0];
      end
      EXT_HALF, EXT_HALFU: begin
        st_wdata = {2{wdata_q[15:0]}};
        st_strb  = 4'b0011 << addr_q[1:0];
      end
      default: begin
        st_wdata = wdata_q;
        st_strb  = 4'b1111;
      end
    endcase
  end

  // err_q and rdata_q are only ever nonzero while in RESP.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ctrl_d     = ctrl_q;
    err_d      = 1'b0;
    rdata_d    = '0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          ctrl_d  = req_ctrl;
          if (req_legal(req_ctrl, req_addr[1:0])) begin
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = we_q ? st_wdata : 32'd0;
        mem_wstrb = we_q ? st_strb : 4'd0;
        if (mem_ready) begin
          if (we_q) begin
            state_d = ST_RESP;
          end else if (mem_rvalid) begin
            rdata_d = rd_ext;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = rd_ext;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: hand-computed loads, stores, illegal requests
// and reset mid-transaction.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ctrl;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk;
  int n_pass;

  lsu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ctrl   (req_ctrl),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [2:0] ctrl);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_ctrl  = ctrl;
    cyc();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_ctrl  = '0;
  endtask

  task automatic bus_idle();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_ctrl = '0;
    bus_idle();
    cyc();
    cyc();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Load BYTE 0x103, rvalid one cycle after ready
    send(1'b0, 32'h0000_0103, 32'd0, EXT_BYTE);
    chk("lb_mem_valid", {31'd0, mem_valid}, 32'd1);
    chk("lb_mem_addr", mem_addr, 32'h0000_0100);
    chk("lb_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("lb_req_ready_c1", {31'd0, req_ready}, 32'd0);
    mem_ready = 1'b1;
    cyc();
    bus_idle();
    chk("lb_wait_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("lb_wait_resp_valid", {31'd0, resp_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80AB_CDEF;
    cyc();
    bus_idle();
    chk("lb_resp_valid_c3", {31'd0, resp_valid}, 32'd1);
    chk("lb_resp_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("lb_resp_err", {31'd0, resp_err}, 32'd0);
    cyc();
    chk("lb_resp_pulse_end", {31'd0, resp_valid}, 32'd0);
    chk("lb_req_ready_back", {31'd0, req_ready}, 32'd1);

    // Load HALFU 0x102, ready+rvalid together
    send(1'b0, 32'h0000_0102, 32'd0, EXT_HALFU);
    chk("lhu_mem_addr", mem_addr, 32'h0000_0100);
    mem_ready  = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8001_1234;
    cyc();
    bus_idle();
    chk("lhu_resp_valid_c2", {31'd0, resp_valid}, 32'd1);
    chk("lhu_resp_rdata", resp_rdata, 32'h0000_8001);
    cyc();
    chk("lhu_req_ready_back", {31'd0, req_ready}, 32'd1);

    // Store HALF 0x206, mem_ready delayed two cycles
    send(1'b1, 32'h0000_0206, 32'hDEAD_BEEF, EXT_HALF);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sh_mem_valid_%0d", i), {31'd0, mem_valid}, 32'd1);
      chk($sformatf("sh_mem_we_%0d", i), {31'd0, mem_we}, 32'd1);
      chk($sformatf("sh_mem_addr_%0d", i), mem_addr, 32'h0000_0204);
      chk($sformatf("sh_mem_wstrb_%0d", i), {28'd0, mem_wstrb}, 32'h0000_000C);
      chk($sformatf("sh_mem_wdata_%0d", i), mem_wdata, 32'hBEEF_BEEF);
      if (i == 2) mem_ready = 1'b1;
      cyc();
    end
    bus_idle();
    chk("sh_resp_valid_c4", {31'd0, resp_valid}, 32'd1);
    chk("sh_resp_rdata", resp_rdata, 32'd0);
    chk("sh_resp_err", {31'd0, resp_err}, 32'd0);
    cyc();

    // Misaligned WORD load 0x101
    send(1'b0, 32'h0000_0101, 32'd0, EXT_WORD);
    chk("lw_mis_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("lw_mis_resp_valid_c1", {31'd0, resp_valid}, 32'd1);
    chk("lw_mis_resp_err", {31'd0, resp_err}, 32'd1);
    chk("lw_mis_resp_rdata", resp_rdata, 32'd0);
    cyc();
    chk("lw_mis_err_clear", {31'd0, resp_err}, 32'd0);

    // Unknown code 3
    send(1'b1, 32'h0000_0400, 32'h1111_2222, 3'd3);
    chk("bad_code_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("bad_code_resp_err", {31'd0, resp_err}, 32'd1);
    cyc();

    // Reset in WAIT, stale rvalid afterwards
    send(1'b0, 32'h0000_0300, 32'd0, EXT_WORD);
    mem_ready = 1'b1;
    cyc();
    bus_idle();
    rst_n = 1'b0;
    #1;
    chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
    cyc();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("rstw_no_resp_%0d", i), {31'd0, resp_valid}, 32'd0);
      chk($sformatf("rstw_rdata_%0d", i), resp_rdata, 32'd0);
      chk($sformatf("rstw_ready_%0d", i), {31'd0, req_ready}, 32'd1);
    end
    bus_idle();

    // Normal store BYTE at 0x1 after the reset
    send(1'b1, 32'h0000_0001, 32'h0000_005A, EXT_BYTE);
    chk("sb_mem_wstrb", {28'd0, mem_wstrb}, 32'h0000_0002);
    chk("sb_mem_wdata", mem_wdata, 32'h5A5A_5A5A);
    chk("sb_mem_addr", mem_addr, 32'h0000_0000);
    mem_ready = 1'b1;
    cyc();
    bus_idle();
    chk("sb_resp_valid", {31'd0, resp_valid}, 32'd1);
    cyc();

    // Aligned WORD load, same-cycle data
    send(1'b0, 32'h0000_0300, 32'd0, EXT_WORD);
    mem_ready  = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    cyc();
    bus_idle();
    chk("lw_resp_rdata", resp_rdata, 32'h1234_5678);
    cyc();

    // Load HALF sign-extended at offset 0
    send(1'b0, 32'h0000_0500, 32'd0, EXT_HALF);
    mem_ready  = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_9ABC;
    cyc();
    bus_idle();
    chk("lh_resp_rdata", resp_rdata, 32'hFFFF_9ABC);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
